// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and timing constants for the HM-65162 SRAM controller.
//   state_t  : controller state encoding
//   CNT_W    : width of the wait-state down-counter
//   T_*_NS   : SRAM datasheet limits (ns) at the default 10 ns clock
//   ns2cyc() : ns -> clock cycles, rounded up
//   cyc_m1() : counter load value for an N-cycle state (N = 0 behaves as 1)
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_SETUP,
      W_PULSE,
      W_HOLD,
      R_ACCESS,
      R_TURN
   } state_t;

   localparam int unsigned CNT_W     = 8;

   localparam int unsigned CLK_NS    = 10;
   localparam int unsigned T_AVWL_NS = 10;
   localparam int unsigned T_WLWH_NS = 55;
   localparam int unsigned T_WHAX_NS = 15;
   localparam int unsigned T_WHDX_NS = 20;
   localparam int unsigned T_AVQV_NS = 90;
   localparam int unsigned T_EHQZ_NS = 50;

   function automatic int unsigned ns2cyc(input int unsigned ns, input int unsigned clk_ns);
      return (ns + clk_ns - 1) / clk_ns;
   endfunction

   function automatic logic [CNT_W-1:0] cyc_m1(input int unsigned n);
      if (n <= 1)
         return '0;
      else
         return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// sram_wait_cnt: loadable wait-state down-counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : load load_val_i this edge (takes priority over counting)
//   load_val_i   : cycles-minus-one for the state being entered
//   done_o       : high while the count is zero (last cycle of the state)
module sram_wait_cnt
   import sram_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: host-side controller for a 2K x 8 asynchronous HM-65162 SRAM.
// Turns single-cycle valid/ready requests into clock-counted async read/write cycles.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we/addr/wdata       : request fields, latched on acceptance
//   rd_valid, rd_data       : read result, rd_valid high for one cycle
//   wr_done                 : one-cycle write-complete pulse
//   wr_err                  : readback mismatch flag (SRAM_CTRL_VERIFY_EN only)
//   Address, Data, SRG/SRE/SRW : registered SRAM pins, strobes active low
// Build option: define SRAM_CTRL_VERIFY_EN to follow every write with a readback compare.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned SETUP_CYC    = 2,
   parameter int unsigned WR_PULSE_CYC = 7,
   parameter int unsigned HOLD_CYC     = 2,
   parameter int unsigned RD_ACC_CYC   = 10,
   parameter int unsigned TURN_CYC     = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              wr_done,
`ifdef SRAM_CTRL_VERIFY_EN
   output logic              wr_err,
`endif
   output logic [ADDR_W-1:0] Address,
   inout  logic [DATA_W-1:0] Data,
   output logic              SRG,
   output logic              SRE,
   output logic              SRW
);

   localparam logic [CNT_W-1:0] SETUP_M1 = cyc_m1(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_M1 = cyc_m1(WR_PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_M1  = cyc_m1(HOLD_CYC);
   localparam logic [CNT_W-1:0] RDACC_M1 = cyc_m1(RD_ACC_CYC);
   localparam logic [CNT_W-1:0] TURN_M1  = cyc_m1(TURN_CYC);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                oe_q, oe_d;
   logic                sre_q, sre_d;
   logic                srg_q, srg_d;
   logic                srw_q, srw_d;
   logic                turn1_q, turn1_d;
   logic                cnt_load;
   logic [CNT_W-1:0]    cnt_val;
   logic                cnt_done;
`ifdef SRAM_CTRL_VERIFY_EN
   logic                vf_q, vf_d;
   logic                err_q, err_d;
`endif

   sram_wait_cnt u_wait (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .done_o     (cnt_done)
   );

   // All pin values are computed as next-state so every SRAM pin leaves a flop.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      rdata_d  = rdata_q;
      oe_d     = oe_q;
      sre_d    = sre_q;
      srg_d    = srg_q;
      srw_d    = srw_q;
      turn1_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = '0;
`ifdef SRAM_CTRL_VERIFY_EN
      vf_d     = vf_q;
      err_d    = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               dout_d   = req_wdata;
               sre_d    = 1'b0;
               cnt_load = 1'b1;
`ifdef SRAM_CTRL_VERIFY_EN
               vf_d     = 1'b0;
`endif
               if (req_we) begin
                  state_d = W_SETUP;
                  oe_d    = 1'b1;
                  cnt_val = SETUP_M1;
               end else begin
                  state_d = R_ACCESS;
                  srg_d   = 1'b0;
                  cnt_val = RDACC_M1;
               end
            end
         end
         W_SETUP: begin
            if (cnt_done) begin
               state_d  = W_PULSE;
               srw_d    = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = PULSE_M1;
            end
         end
         W_PULSE: begin
            if (cnt_done) begin
               state_d  = W_HOLD;
               srw_d    = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = HOLD_M1;
            end
         end
         W_HOLD: begin
            if (cnt_done) begin
               // Bus release and SRG fall share one edge, so the pins never overlap.
               oe_d = 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
               state_d  = R_ACCESS;
               srg_d    = 1'b0;
               vf_d     = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = RDACC_M1;
`else
               state_d  = IDLE;
               sre_d    = 1'b1;
`endif
            end
         end
         R_ACCESS: begin
            if (cnt_done) begin
               state_d  = R_TURN;
               sre_d    = 1'b1;
               srg_d    = 1'b1;
               turn1_d  = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = TURN_M1;
`ifdef SRAM_CTRL_VERIFY_EN
               if (vf_q)
                  err_d = (Data != dout_q);
               else
                  rdata_d = Data;
`else
               rdata_d = Data;
`endif
            end
         end
         R_TURN: begin
            if (cnt_done)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         dout_q  <= '0;
         rdata_q <= '0;
         oe_q    <= 1'b0;
         sre_q   <= 1'b1;
         srg_q   <= 1'b1;
         srw_q   <= 1'b1;
         turn1_q <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
         vf_q    <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         rdata_q <= rdata_d;
         oe_q    <= oe_d;
         sre_q   <= sre_d;
         srg_q   <= srg_d;
         srw_q   <= srw_d;
         turn1_q <= turn1_d;
`ifdef SRAM_CTRL_VERIFY_EN
         vf_q    <= vf_d;
         err_q   <= err_d;
`endif
      end
   end

   assign req_ready = (state_q == IDLE);
   assign Address   = addr_q;
   assign Data      = oe_q ? dout_q : 'z;
   assign SRG       = srg_q;
   assign SRE       = sre_q;
   assign SRW       = srw_q;
   assign rd_data   = rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
   // Verify reads report through wr_done/wr_err instead of rd_valid.
   assign rd_valid  = turn1_q & ~vf_q;
   assign wr_done   = turn1_q & vf_q;
   assign wr_err    = err_q;
`else
   assign rd_valid  = turn1_q;
   assign wr_done   = (state_q == W_HOLD) & cnt_done;
`endif

endmodule
